// File: rtl/sid_cmd_router_pkg.sv
// sid_pkg: shared types for the SID command router.
// Holds the SID bus address width, the chip-count ceiling, the queued write
// record and the header/data parser state encoding.
package sid_pkg;

    localparam int SID_ADDR_W    = 5;
    localparam int SID_MAX_CHIPS = 8;

    // One queued register write: target chip, register address, write data.
    typedef struct packed {
        logic [2:0]            chip;
        logic [SID_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } sid_wr_t;

    // HDR waits for {chip, addr}; DATA waits for the write data byte.
    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } parser_state_t;

endpackage

// File: rtl/sid_cmd_router_wr_fifo.sv
// sid_wr_fifo: synchronous write queue of sid_wr_t records.
// No fall-through: an entry written in cycle T is visible on rdata from T+1.
// level counts 0..DEPTH inclusive; push when full and pop when empty are ignored.
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  sid_wr_t                wdata,
    output sid_wr_t                rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    sid_wr_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_reg;
    assign rdata   = mem[rd_ptr_reg];

    // Storage array: written only, never reset (contents are don't-care when empty).
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/sid_cmd_router.sv
// sid_cmd_router: decodes a {chip,addr} header byte plus a data byte into
// queued SID register writes, issuing at most one write per clk_en period.
// Optional build macro SID_CMD_TIMEOUT_EN: when defined, a DATA-state idle
// counter abandons a frame after TIMEOUT_CYCLES cycles and pulses err_timeout;
// when undefined the parser waits indefinitely and err_timeout stays 0.
module sid_cmd_router
    import sid_pkg::*;
#(
    parameter int N_CHIPS        = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic [7:0]                  in_tdata,
    input  logic                        in_tvalid,
    output logic                        in_tready,
    output logic [SID_ADDR_W-1:0]       bus_addr,
    output logic [7:0]                  bus_data,
    output logic [N_CHIPS-1:0]          bus_cs_n,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_hdr,
    output logic                        err_timeout
);

    localparam logic [3:0] N_CHIPS_L = 4'(N_CHIPS);

    parser_state_t         state_reg;
    logic [2:0]            chip_reg;
    logic [SID_ADDR_W-1:0] addr_reg;
    logic                  err_hdr_reg;
    logic                  err_timeout_reg;
    logic [SID_ADDR_W-1:0] bus_addr_reg;
    logic [7:0]            bus_data_reg;
    logic [N_CHIPS-1:0]    bus_cs_n_reg;
    logic [N_CHIPS-1:0]    sel_n;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  hdr_ok;
    logic                  timeout_hit;
    sid_wr_t               push_wr;
    sid_wr_t               head_wr;

    // Only TIMEOUT_CYCLES >= 1 is meaningful; the range test keeps the parameter referenced in every build.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_out_of_range
    end

    assign in_tready = !fifo_full;
    assign accept    = in_tvalid && in_tready;
    assign hdr_ok    = ({1'b0, in_tdata[7:5]} < N_CHIPS_L);
    assign push      = accept && (state_reg == DATA);
    assign pop       = clk_en && !fifo_empty;
    assign push_wr   = {chip_reg, addr_reg, in_tdata};

`ifdef SID_CMD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr_reg;
    assign timeout_hit = (tmr_reg == TMR_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Active-low select for the chip at the head of the queue.
    for (genvar gi = 0; gi < N_CHIPS; gi++) begin : g_sel
        assign sel_n[gi] = (head_wr.chip != 3'(gi));
    end

    sid_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_wr),
        .rdata (head_wr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Header/data parser with registered error pulses and optional idle timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= HDR;
            chip_reg        <= '0;
            addr_reg        <= '0;
            err_hdr_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
`ifdef SID_CMD_TIMEOUT_EN
            tmr_reg         <= '0;
`endif
        end else begin
            err_hdr_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            case (state_reg)
                HDR: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            chip_reg  <= in_tdata[7:5];
                            addr_reg  <= in_tdata[4:0];
                            state_reg <= DATA;
                        end else begin
                            err_hdr_reg <= 1'b1;
                        end
                    end
`ifdef SID_CMD_TIMEOUT_EN
                    tmr_reg <= '0;
`endif
                end
                DATA: begin
                    if (accept) begin
                        state_reg <= HDR;
                    end else if (timeout_hit) begin
                        state_reg       <= HDR;
                        err_timeout_reg <= 1'b1;
                    end
`ifdef SID_CMD_TIMEOUT_EN
                    tmr_reg <= (accept || timeout_hit) ? '0 : tmr_reg + TMR_W'(1);
`endif
                end
                default: state_reg <= HDR;
            endcase
        end
    end

    // Bus issue: one queued write per clk_en; outputs hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr_reg <= '0;
            bus_data_reg <= '0;
            bus_cs_n_reg <= '1;
        end else if (clk_en) begin
            if (!fifo_empty) begin
                bus_addr_reg <= head_wr.addr;
                bus_data_reg <= head_wr.data;
                bus_cs_n_reg <= sel_n;
            end else begin
                bus_cs_n_reg <= '1;
            end
        end
    end

    assign bus_addr    = bus_addr_reg;
    assign bus_data    = bus_data_reg;
    assign bus_cs_n    = bus_cs_n_reg;
    assign err_hdr     = err_hdr_reg;
    assign err_timeout = err_timeout_reg;

endmodule
